booth_seq_ctrl: RTL and testbench



---
 rtl/booth_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_booth_seq_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth controller that time-shares one external add/subtract datapath.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses the iterations and finishes at once.
module booth_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               as_cin,
    output logic [WIDTH-1:0]   as_i0,
    output logic [WIDTH-1:0]   as_i1,
    input  logic [WIDTH-1:0]   as_sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t                   state_q;
    logic signed [WIDTH-1:0]  a_q;
    logic        [WIDTH-1:0]  q_q;
    logic                     q1_q;
    logic signed [WIDTH-1:0]  m_q;
    logic        [CNT_W-1:0]  cnt_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;

    logic [1:0]               op_sel;
    logic                     do_op;
    logic                     sub_op;
    logic [WIDTH-1:0]         b_op;
    logic [WIDTH-1:0]         s_val;
    logic                     g_bit;
    logic signed [WIDTH-1:0]  a_d;
    logic        [WIDTH-1:0]  q_d;
    logic                     q1_d;

    // True sign of the (WIDTH+1)-bit sum: on two's-complement overflow the result
    // sign is the common operand sign, not the wrapped sum MSB.
    function automatic logic guard_bit(input logic op, input logic a_msb,
                                       input logic b_msb, input logic s_msb);
        logic ovf;
        ovf = (a_msb == b_msb) && (s_msb != a_msb);
        if (!op)
            guard_bit = a_msb;
        else if (ovf)
            guard_bit = a_msb;
        else
            guard_bit = s_msb;
    endfunction

    always_comb begin
        op_sel = {q_q[0], q1_q};
        do_op  = (state_q == CALC) && ((op_sel == 2'b01) || (op_sel == 2'b10));
        sub_op = (state_q == CALC) && (op_sel == 2'b10);
        b_op   = m_q ^ {WIDTH{sub_op}};
        s_val  = do_op ? as_sum : a_q;
        g_bit  = guard_bit(do_op, a_q[WIDTH-1], b_op[WIDTH-1], as_sum[WIDTH-1]);
        {a_d, q_d, q1_d} = {g_bit, s_val, q_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            q1_q        <= 1'b0;
            m_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= '0;
                        q1_q       <= 1'b0;
                        m_q        <= multiplicand;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef BOOTH_ZERO_SKIP_EN
                        if ((multiplicand == '0) || (multiplier == '0)) begin
                            q_q         <= '0;
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            q_q     <= multiplier;
                            state_q <= CALC;
                        end
`else
                        q_q     <= multiplier;
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = out_valid_q ? {a_q, q_q} : '0;
    assign as_cin    = sub_op;
    assign as_i0     = a_q;
    assign as_i1     = m_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl with a behavioural model of the external add/subtract datapath.
module tb_booth_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;
    logic        as_cin;
    logic [7:0]  as_i0;
    logic [7:0]  as_i1;
    logic [7:0]  as_sum;

    int total;
    int bad;

    booth_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy),
        .as_cin       (as_cin),
        .as_i0        (as_i0),
        .as_i1        (as_i1),
        .as_sum       (as_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ripple adder: cin=1 inverts i1 and adds one, i.e. subtracts.
    always_comb as_sum = as_i0 + (as_i1 ^ {8{as_cin}}) + 8'(as_cin);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle, then run until out_valid rises (bounded).
    task automatic do_mul(input string tag, input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp_p, input int exp_lat, input logic [7:0] exp_mask);
        int         cyc;
        logic [7:0] mask;
        mask = 8'h00;
        @(posedge clk); #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk); #1;
        in_valid     = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        cyc = 1;
        check({tag, " as_i1"}, 32'(as_i1), 32'(m));
        while (!out_valid && cyc < 40) begin
            if (cyc <= 8) mask[cyc-1] = as_cin;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " product"}, 32'(product), 32'(exp_p));
        check({tag, " cin_mask"}, 32'(mask), 32'(exp_mask));
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " in_ready_low"}, 32'(in_ready), 32'd0);
    endtask

    // After a handshake with out_ready=1 the controller must be idle again.
    task automatic check_idle(input string tag);
        @(posedge clk); #1;
        check({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, " product_zero"}, 32'(product), 32'd0);
    endtask

    int         zlat;
    logic [7:0] zmask;

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        #12;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst product", 32'(product), 32'd0);
        check("rst as_cin", 32'(as_cin), 32'd0);
        check("rst as_i0", 32'(as_i0), 32'd0);
        rst_n = 1'b1;

        do_mul("basic", 8'h03, 8'h05, 16'h000F, 9, 8'h05);
        check_idle("basic");
        do_mul("mixed", 8'hF9, 8'h06, 16'hFFD6, 9, 8'h02);
        check_idle("mixed");
        do_mul("m80x80", 8'h80, 8'h80, 16'h4000, 9, 8'h80);
        check_idle("m80x80");
        do_mul("m80x7F", 8'h80, 8'h7F, 16'hC080, 9, 8'h01);
        check_idle("m80x7F");
        do_mul("m7Fx80", 8'h7F, 8'h80, 16'hC080, 9, 8'h80);
        check_idle("m7Fx80");

        out_ready = 1'b0;
        do_mul("bp", 8'h12, 8'h34, 16'h03A8, 9, 8'h14);
        for (int i = 0; i < 5; i++) begin
            in_valid     = (i == 2);
            multiplicand = 8'h11;
            multiplier   = 8'h22;
            @(posedge clk); #1;
            check("bp hold product", 32'(product), 32'h03A8);
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold busy", 32'(busy), 32'd1);
            check("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_idle("bp release");
        check("bp busy_clear", 32'(busy), 32'd0);

        @(posedge clk); #1;
        in_valid     = 1'b1;
        multiplicand = 8'h55;
        multiplier   = 8'h33;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst product", 32'(product), 32'd0);
        check("midrst as_i0", 32'(as_i0), 32'd0);
        check("midrst as_i1", 32'(as_i1), 32'd0);
        check("midrst as_cin", 32'(as_cin), 32'd0);
        #4;
        rst_n = 1'b1;
        do_mul("post_rst", 8'h7F, 8'h7F, 16'h3F01, 9, 8'h01);
        check_idle("post_rst");

`ifdef BOOTH_ZERO_SKIP_EN
        zlat  = 1;
        zmask = 8'h00;
`else
        zlat  = 9;
        zmask = 8'h55;
`endif
        do_mul("zero", 8'h00, 8'h55, 16'h0000, zlat, zmask);
        check_idle("zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
